// File: rtl/bus_ctrl.sv
// Address-decoding bus controller between a picorv32 master and four slaves.
// Routes each request to one slave, and turns unmapped or timed-out accesses into error responses.
module bus_ctrl #(
    parameter logic [3:0]  BASE0    = 4'h0,
    parameter logic [3:0]  BASE1    = 4'h2,
    parameter logic [3:0]  BASE2    = 4'h8,
    parameter logic [3:0]  BASE3    = 4'hF,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [3:0]  enable,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    input  logic        err_clr,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    // state  | meaning
    // IDLE   | waiting for mem_valid; decodes the address
    // ACCESS | one slave enabled, waiting for s_ready or timeout
    // DONE   | mem_ready pulse to the master for one cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last ACCESS cycle is the one where the counter reaches TIMEOUT-1.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [3:0]  enable_nxt;
    logic        mem_ready_nxt;
    logic [31:0] mem_rdata_nxt;
    logic        bus_err_nxt;
    logic [31:0] err_addr_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [31:0] addr_lat, addr_lat_nxt;

    logic [3:0]  sel;
    logic        mapped;

    // Lowest index wins when bases are duplicated.
    always_comb begin
        sel    = 4'b0000;
        mapped = 1'b1;
        if (mem_addr[31:28] == BASE0)
            sel = 4'b0001;
        else if (mem_addr[31:28] == BASE1)
            sel = 4'b0010;
        else if (mem_addr[31:28] == BASE2)
            sel = 4'b0100;
        else if (mem_addr[31:28] == BASE3)
            sel = 4'b1000;
        else
            mapped = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            enable    <= 4'b0000;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            bus_err   <= 1'b0;
            err_addr  <= 32'h0;
            cnt       <= 16'h0;
            addr_lat  <= 32'h0;
        end else begin
            state     <= state_nxt;
            enable    <= enable_nxt;
            mem_ready <= mem_ready_nxt;
            mem_rdata <= mem_rdata_nxt;
            bus_err   <= bus_err_nxt;
            err_addr  <= err_addr_nxt;
            cnt       <= cnt_nxt;
            addr_lat  <= addr_lat_nxt;
        end
    end

    // A new error in the same cycle as err_clr overrides the clear below.
    always_comb begin
        state_nxt     = state;
        enable_nxt    = 4'b0000;
        mem_ready_nxt = 1'b0;
        mem_rdata_nxt = mem_rdata;
        bus_err_nxt   = err_clr ? 1'b0 : bus_err;
        err_addr_nxt  = err_addr;
        cnt_nxt       = cnt;
        addr_lat_nxt  = addr_lat;

        unique case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (mapped) begin
                        enable_nxt   = sel;
                        cnt_nxt      = 16'h0;
                        addr_lat_nxt = mem_addr;
                        state_nxt    = ACCESS;
                    end else begin
                        mem_ready_nxt = 1'b1;
                        mem_rdata_nxt = ERR_DATA;
                        bus_err_nxt   = 1'b1;
                        err_addr_nxt  = mem_addr;
                        state_nxt     = DONE;
                    end
                end
            end
            ACCESS: begin
                if (s_ready) begin
                    mem_ready_nxt = 1'b1;
                    mem_rdata_nxt = s_rdata;
                    state_nxt     = DONE;
                end else if (cnt == CNT_LAST) begin
                    mem_ready_nxt = 1'b1;
                    mem_rdata_nxt = ERR_DATA;
                    bus_err_nxt   = 1'b1;
                    err_addr_nxt  = addr_lat;
                    state_nxt     = DONE;
                end else begin
                    enable_nxt = enable;
                    cnt_nxt    = cnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 The block SHALL have parameter BASE0, default 4'h0, mem_addr[31:28] value selecting slave 0.
REQ-002 The block SHALL have parameter BASE1, default 4'h2, mem_addr[31:28] value selecting slave 1.
REQ-003 The block SHALL have parameter BASE2, default 4'h8, mem_addr[31:28] value selecting slave 2.
REQ-004 The block SHALL have parameter BASE3, default 4'hF, mem_addr[31:28] value selecting slave 3.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, legal 2..65535, maximum ACCESS cycles without slave ready.
REQ-006 The block SHALL have parameter ERR_DATA, default 32'hDEADBEEF, read data returned on any error response.
REQ-007 The block SHALL have one clock and an asynchronous, active-high reset (ports clk and reset).
REQ-008 clk  input  1  rising-edge clock for all state.
REQ-009 reset  input  1  asynchronous active-high reset.
REQ-010 mem_valid  input  1  master request from picorv32.
REQ-011 mem_addr  input  32  master address.
REQ-012 mem_ready  output  1  registered completion pulse to master.
REQ-013 mem_rdata  output  32  registered read data to master.
REQ-014 enable  output  4  one-hot registered slave select; bit k drives slave k enable.
REQ-015 s_ready  input  1  wire-OR of all slave mem_ready (unselected slaves drive 0).
REQ-016 s_rdata  input  32  wire-OR of all slave mem_rdata.
REQ-017 err_clr  input  1  synchronous clear of error status.
REQ-018 bus_err  output  1  sticky error flag.
REQ-019 err_addr  output  32  mem_addr of the most recent errored transfer.
REQ-020 mem_wdata/mem_wstrb/mem_instr SHALL be routed directly from master to slaves outside this block.

Function
REQ-021 Decode SHALL compare mem_addr[31:28] against BASE0..BASE3; lowest index wins on duplicate bases; no match = unmapped.
REQ-022 FSM states SHALL be IDLE, ACCESS, DONE; reset state IDLE.
REQ-023 IDLE, mem_valid=1, mapped slave k: next cycle enable[k]=1, cycle counter=0, state ACCESS.
REQ-024 IDLE, mem_valid=1, unmapped: next cycle state DONE, mem_ready=1, mem_rdata=ERR_DATA, bus_err=1, err_addr=mem_addr; enable stays 0.
REQ-025 IDLE, mem_valid=0: all outputs hold; enable=0, mem_ready=0.
REQ-026 ACCESS, s_ready=1: next cycle mem_ready=1, mem_rdata=s_rdata, enable=0, state DONE.
REQ-027 ACCESS, s_ready=0, counter<TIMEOUT-1: counter increments by 1, enable held.
REQ-028 ACCESS, s_ready=0, counter=TIMEOUT-1: next cycle mem_ready=1, mem_rdata=ERR_DATA, enable=0, bus_err=1, err_addr=address latched at IDLE, state DONE.
REQ-029 Counter SHALL be 16 bits and never wrap within one transfer.
REQ-030 s_ready and timeout in the same ACCESS cycle: s_ready wins, no error.
REQ-031 DONE: mem_ready=1 for exactly this one cycle; next cycle state IDLE, mem_ready=0.
REQ-032 mem_rdata SHALL hold its last value until the next completion.
REQ-033 Address SHALL be latched at IDLE->ACCESS; mem_addr changes during ACCESS ignored.
REQ-034 mem_valid dropping during ACCESS SHALL NOT abort; transfer completes normally.
REQ-035 Mapped slave latency: mem_valid seen cycle 0 -> enable cycle 1 -> mem_ready cycle N+2 where slave asserts ready cycle N+1 (GPIO: mem_ready cycle 3).
REQ-036 err_clr=1 clears bus_err next cycle; err_addr retained; new error in same cycle as err_clr wins (bus_err=1).
REQ-037 Back-to-back: mem_valid high in cycle after DONE starts a new transfer from IDLE.

Reset
REQ-038 reset=1 SHALL immediately force state IDLE, enable=0, mem_ready=0, mem_rdata=0, bus_err=0, err_addr=0, counter=0, including mid-ACCESS.
REQ-039 After reset release, first transfer SHALL start on the first rising edge with mem_valid=1.

Verification
REQ-040 Read 0x20000000 (BASE1=2), slave ready 1 cycle after enable, s_rdata=0x000000A5 -> enable=4'b0010 cycle 1, mem_ready cycle 3, mem_rdata=0x000000A5, bus_err=0.
REQ-041 Access 0x40000000 (unmapped) -> mem_ready cycle 1, mem_rdata=0xDEADBEEF, bus_err=1, err_addr=0x40000000, enable never set.
REQ-042 TIMEOUT=4, access 0x80000010, s_ready held 0 -> enable[2] high cycles 1-4, mem_ready cycle 5, mem_rdata=0xDEADBEEF, err_addr=0x80000010.
REQ-043 TIMEOUT=4, s_ready=1 in final ACCESS cycle -> normal completion, mem_rdata=s_rdata, bus_err=0.
REQ-044 bus_err=1, err_clr=1 coinciding with new unmapped error -> bus_err stays 1; err_clr alone -> bus_err=0 next cycle, err_addr unchanged.
REQ-045 reset asserted mid-ACCESS on 0xF0000000 -> enable=0, mem_ready=0 immediately; post-reset read completes normally.
